// File: rtl/ahb_sram_master.sv
// AHB-Lite initiator: turns one local command into a SINGLE or INCR burst of
// 8/16/32-bit beats, with wait-state, ERROR-abort and read-return handling.
module ahb_sram_master (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [3:0]  cmd_len,
    output logic        wr_req,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST_DATA, S_ERR} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [4:0]  beats_q, beats_d;
    logic        dphase_q, dphase_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bus_err;
    logic [31:0] next_addr;
    logic [31:0] align_mask;

    assign bus_err   = (hresp != 2'b00);
    assign next_addr = haddr_q + (32'd1 << hsize_q);

    always_comb begin
        align_mask = 32'hFFFF_FFFF;
        if (cmd_size == 3'd1) align_mask = 32'hFFFF_FFFE;
        if (cmd_size == 3'd2) align_mask = 32'hFFFF_FFFC;
    end

    always_comb begin
        state_d    = state_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        beats_d    = beats_q;
        dphase_d   = dphase_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_size > 3'd2) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = TR_NONSEQ;
                        haddr_d  = cmd_addr & align_mask;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        hburst_d = (cmd_len == 4'd1) ? 3'd0 : 3'd1;
                        beats_d  = (cmd_len == 4'd0) ? 5'd16 : {1'b0, cmd_len};
                        dphase_d = 1'b0;
                    end
                end
            end
            S_ADDR: begin
                if (dphase_q && bus_err) begin
                    // Cancel the pending address phase; finish once the slave completes the response.
                    htrans_d = TR_IDLE;
                    dphase_d = 1'b0;
                    if (hready) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (hready) begin
                    if (dphase_q && !hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = hrdata;
                    end
                    if (hwrite_q) hwdata_d = wr_data;
                    dphase_d = 1'b1;
                    if (beats_q == 5'd1) begin
                        state_d  = S_LAST_DATA;
                        htrans_d = TR_IDLE;
                    end else begin
                        beats_d  = beats_q - 5'd1;
                        haddr_d  = next_addr;
                        htrans_d = (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                    end
                end
            end
            S_LAST_DATA: begin
                if (bus_err) begin
                    dphase_d = 1'b0;
                    if (hready) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (hready) begin
                    if (!hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = hrdata;
                    end
                    state_d  = S_IDLE;
                    dphase_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            S_ERR: begin
                htrans_d = TR_IDLE;
                if (hready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q    <= S_IDLE;
            htrans_q   <= TR_IDLE;
            haddr_q    <= 32'd0;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'd0;
            hburst_q   <= 3'd0;
            hwdata_q   <= 32'd0;
            beats_q    <= 5'd0;
            dphase_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            beats_q    <= beats_d;
            dphase_q   <= dphase_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_req    = (state_q == S_ADDR) && hwrite_q && hready;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_sram_master.sv
// Directed bench for ahb_sram_master: a behavioural AHB slave plus scoreboard
// queues of expected address phases, write data and read returns.
module tb_ahb_sram_master;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_len;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ahb_sram_master dut (
        .hclk(hclk), .hrst(hrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_req(wr_req), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [40:0] exp_addr_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [31:0] exp_rd_q[$];

    logic        dph_valid = 1'b0;
    logic [31:0] dph_addr  = 32'd0;
    logic        dph_write = 1'b0;
    logic        prev_err_first = 1'b0;
    int          rel = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          done_rel = -1;
    logic        saw_err = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One bus cycle: drive slave inputs, sample at negedge, advance slave pipeline.
    task automatic step(input logic hr, input logic [1:0] rs);
        logic        nxt_valid;
        logic [31:0] nxt_addr;
        logic        nxt_write;
        logic [40:0] e;
        nxt_valid = 1'b0;
        nxt_addr  = 32'd0;
        nxt_write = 1'b0;
        hready  = hr;
        hresp   = rs;
        hrdata  = dph_valid ? mem_word(dph_addr) : 32'hDEAD_BEEF;
        wr_data = 32'hC0DE_0000 | (32'(cyc) & 32'h0000_FFFF);
        @(negedge hclk);
        if (prev_err_first) chk("htrans_idle_after_err", 128'(htrans), 128'(2'b00));
        chk("wr_req", 128'(wr_req), 128'((htrans != 2'b00) && hwrite && hready));
        if (htrans != 2'b00 && hready) begin
            chk("addr_phase_expected", 128'(exp_addr_q.size() != 0), 128'(1));
            if (exp_addr_q.size() != 0) begin
                e = exp_addr_q.pop_front();
                chk("addr_phase", 128'({haddr, htrans, hwrite, hsize, hburst}), 128'(e));
            end
            nxt_valid = 1'b1;
            nxt_addr  = haddr;
            nxt_write = hwrite;
            if (hwrite) exp_wdata_q.push_back(wr_data);
        end
        if (dph_valid && dph_write && hready && hresp == 2'b00) begin
            chk("wdata_expected", 128'(exp_wdata_q.size() != 0), 128'(1));
            if (exp_wdata_q.size() != 0) chk("hwdata", 128'(hwdata), 128'(exp_wdata_q.pop_front()));
        end
        if (rd_valid) begin
            chk("rd_expected", 128'(exp_rd_q.size() != 0), 128'(1));
            if (exp_rd_q.size() != 0) chk("rd_data", 128'(rd_data), 128'(exp_rd_q.pop_front()));
        end
        if (done) begin
            done_count++;
            done_rel = rel;
            saw_err  = err;
        end
        prev_err_first = (hresp != 2'b00) && !hready;
        @(posedge hclk);
        if (hrst) dph_valid = 1'b0;
        else if (hready) begin
            dph_valid = nxt_valid;
            dph_addr  = nxt_addr;
            dph_write = nxt_write;
        end
        #1;
        rel++;
        cyc++;
    endtask

    // Issue one command, run until done (bounded), then check timing and scoreboard state.
    task automatic run_cmd(input string name, input logic wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [3:0] ln,
                           input logic [31:0] wait_mask, input logic [31:0] err_mask,
                           input int exp_done, input logic exp_err, input int exp_left);
        int          n;
        logic [31:0] ad;
        logic [1:0]  tr;
        exp_addr_q.delete();
        exp_wdata_q.delete();
        exp_rd_q.delete();
        n = (ln == 4'd0) ? 16 : int'(ln);
        if (sz <= 3'd2) begin
            ad = a & ~((32'd1 << sz) - 32'd1);
            for (int k = 0; k < n; k++) begin
                tr = (k == 0 || ad[9:0] == 10'd0) ? 2'b10 : 2'b11;
                exp_addr_q.push_back({ad, tr, wr, sz, (n == 1) ? 3'd0 : 3'd1});
                if (!wr) exp_rd_q.push_back(mem_word(ad));
                ad = ad + (32'd1 << sz);
            end
        end
        rel        = 0;
        done_count = 0;
        done_rel   = -1;
        saw_err    = 1'b0;
        chk({name, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_len   = ln;
        step(!wait_mask[0], err_mask[0] ? 2'b01 : 2'b00);
        cmd_valid = 1'b0;
        while (done_count == 0 && rel < 64)
            step(rel < 32 ? !wait_mask[rel] : 1'b1,
                 (rel < 32 && err_mask[rel]) ? 2'b01 : 2'b00);
        chk({name, "_done_seen"}, 128'(done_count), 128'(1));
        chk({name, "_done_cycle"}, 128'(done_rel), 128'(exp_done));
        chk({name, "_err"}, 128'(saw_err), 128'(exp_err));
        chk({name, "_addr_left"}, 128'(exp_addr_q.size()), 128'(exp_left));
        if (!exp_err) chk({name, "_rd_left"}, 128'(exp_rd_q.size()), 128'(0));
        chk({name, "_ready_after"}, 128'(cmd_ready), 128'(1));
        step(1'b1, 2'b00);
        chk({name, "_done_single_pulse"}, 128'(done_count), 128'(1));
        $display("cmd %s wr=%0b addr=%h size=%0d len=%0d done@%0d err=%0b", name, wr, a, sz, ln,
                 done_rel, saw_err);
    endtask

    initial begin
        hrst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_size = 3'd0; cmd_len = 4'd0;
        wr_data = 32'd0; hready = 1'b1; hresp = 2'b00; hrdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1;
        chk("reset_bus", 128'({htrans, haddr, hwrite, hsize, hburst, hwdata}), 128'(0));
        chk("reset_misc", 128'({rd_data, rd_valid, done, err, cmd_ready}), 128'(1));
        hrst = 1'b0;
        step(1'b1, 2'b00);

        run_cmd("single_wr",  1'b1, 32'h0000_0010, 3'd2, 4'd1, 32'h0,  32'h0,  3,  1'b0, 0);
        run_cmd("rd4_wait",   1'b0, 32'h0000_0100, 3'd2, 4'd4, 32'h8,  32'h0,  7,  1'b0, 0);
        run_cmd("cross_1k",   1'b0, 32'h0000_03F8, 3'd2, 4'd4, 32'h0,  32'h0,  6,  1'b0, 0);
        run_cmd("byte16",     1'b0, 32'h0000_0007, 3'd0, 4'd0, 32'h0,  32'h0,  18, 1'b0, 0);
        run_cmd("half_align", 1'b1, 32'h0000_3FF, 3'd1, 4'd3, 32'h24, 32'h0,  7,  1'b0, 0);
        run_cmd("err_wr",     1'b1, 32'h0000_0200, 3'd2, 4'd4, 32'h8,  32'h18, 5,  1'b1, 2);
        run_cmd("bad_size",   1'b0, 32'h0000_0040, 3'd3, 4'd2, 32'h0,  32'h0,  1,  1'b1, 0);

        // Reset during the third beat of a write burst.
        exp_addr_q.delete(); exp_wdata_q.delete(); exp_rd_q.delete();
        exp_addr_q.push_back({32'h500, 2'b10, 1'b1, 3'd2, 3'd1});
        exp_addr_q.push_back({32'h504, 2'b11, 1'b1, 3'd2, 3'd1});
        exp_addr_q.push_back({32'h508, 2'b11, 1'b1, 3'd2, 3'd1});
        done_count = 0;
        rel = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_size = 3'd2; cmd_len = 4'd4;
        step(1'b1, 2'b00);
        cmd_valid = 1'b0;
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        hrst = 1'b1;
        step(1'b1, 2'b00);
        chk("midrst_bus", 128'({htrans, haddr, hwrite, hsize, hburst, hwdata}), 128'(0));
        chk("midrst_misc", 128'({rd_data, rd_valid, done, err, cmd_ready}), 128'(1));
        hrst = 1'b0;
        exp_addr_q.delete(); exp_wdata_q.delete();
        repeat (5) step(1'b1, 2'b00);
        chk("midrst_no_done", 128'(done_count), 128'(0));
        $display("cmd midrst done_count=%0d", done_count);

        run_cmd("after_rst",  1'b0, 32'h0000_0020, 3'd2, 4'd2, 32'h0,  32'h0,  4,  1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
